branch_cond_unit: RTL and testbench
===================================

// Module: branch_cond_unit
// PURPOSE
//  Registered, parametrised branch-condition evaluator for the pipelined MIPS datapath.
//  Compares two WIDTH-bit operands under a selectable condition mode and reports
//  zero/taken flags a fixed LATENCY later.
//  Supports pipeline stall and flush, and keeps a saturating count of taken branches
//  for performance statistics.
//  Sits between ID/EX operand forwarding and the PC-select logic.
// PARAMETERS
//  WIDTH    32  operand width in bits; must be >= 2
//  LATENCY  1   cycles from accept to result; legal values are 1 and 2 only
//  CNT_W    16  width of the taken-branch counter; must be >= 1
// PORTS
//  clk_i        in   1        clock; all logic is rising-edge
//  rst_i        in   1        synchronous reset, active-high
//  valid_i      in   1        operands and mode on this cycle are a real branch
//  stall_i      in   1        hold every stage register, counter included
//  flush_i      in   1        kill every in-flight result
//  mode_i       in   3        condition select (codes below)
//  src_a_i      in   WIDTH    operand A (rs)
//  src_b_i      in   WIDTH    operand B (rt)
//  cnt_clr_i    in   1        clear the taken counter
//  valid_o      out  1        result registers hold a live result
//  zero_o       out  1        1 iff (src_a - src_b) == 0, i.e. A == B
//  taken_o      out  1        condition true
//  taken_cnt_o  out  CNT_W    saturating count of taken results
// BEHAVIOUR
//  Mode codes (taken_o when):
//   0 EQ  : A == B
//   1 NE  : A != B
//   2 LTZ : $signed(A) < 0
//   3 GEZ : $signed(A) >= 0
//   4 LEZ : $signed(A) <= 0
//   5 GTZ : $signed(A) > 0
//   6 LTU : A < B, unsigned
//   7 NEV : never taken
//  - zero_o is computed for every mode and always tracks A == B.
//  - Arithmetic: the subtraction is WIDTH+1 bits wide, so it never wraps.
//    Sign is taken from bit WIDTH-1 of A.
//  Reset (rst_i = 1): valid_o, zero_o, taken_o, taken_cnt_o and all internal valid bits are 0.
//  LATENCY = 1:
//   - Evaluate inputs combinationally; load the result into the output registers.
//   - Result is visible the cycle after accept.
//  LATENCY = 2:
//   - Stage-1 registers capture A, B, mode and valid.
//   - The evaluation of stage 1 loads into the output registers.
//   - Result is visible 2 cycles after accept.
//  Stage load: when a stage's incoming valid is 0, the stage loads valid = 0 and zero = taken = 0.
//  Output gating: zero_o and taken_o are 0 whenever valid_o = 0.
//  stall_i = 1: every register holds, including the counter. Inputs on that cycle are ignored.
//  flush_i = 1:
//   - Next cycle, all valid bits are 0; zero_o and taken_o are 0.
//   - Inputs on the flush cycle are discarded.
//   - flush overrides stall.
//  Counter:
//   - +1 on each cycle the output register loads valid = 1 with taken = 1.
//   - Saturates at 2^CNT_W - 1; no wrap.
//   - cnt_clr_i forces 0 and beats a coincident increment.
//   - Counter is unaffected by flush.
//  Back-to-back: a new valid_i every cycle yields one result per cycle, in order, no bubbles.
//  Illegal LATENCY, WIDTH < 2 or CNT_W < 1: elaboration-time error via a generate-block $error.
// STRUCTURE
//  - Shared package bcu_pkg: mode localparams BCU_EQ .. BCU_NEV and the 3-bit mode width.
//  - Sub-module bcu_eval (combinational): (A, B, mode) -> {zero, taken}.
//    Zero detect is a reduction NOR of the difference.
//    Instantiated once, placed before or after the stage-1 register according to LATENCY.
//  - Top level holds the stage registers, stall/flush control and the counter.
// TESTING
//  1. Reset 3 cycles, then idle: valid_o = 0, taken_o = 0, taken_cnt_o = 0 every cycle.
//  2. LAT=1, EQ, A=B=0x1234:
//     -> next cycle valid_o = 1, zero_o = 1, taken_o = 1, taken_cnt_o = 1.
//     Then NE with the same operands -> taken_o = 0, zero_o = 1.
//  3. LAT=2, LTZ A=0x80000000, then GTZ A=0, then LTU A=1, B=0xFFFFFFFF, on 3 consecutive cycles:
//     -> from accept+2: taken = 1, 0, 1 on consecutive cycles.
//  4. LAT=2: accept EQ-taken, stall 3 cycles, then flush while stalled:
//     -> outputs held during the stall; valid_o = 0 on the cycle after flush; counter unchanged.
//  5. CNT_W=2: 5 taken results -> taken_cnt_o = 3 and stays 3.
//     Then cnt_clr_i coincident with a taken load -> taken_cnt_o = 0.
//  6. Random A/B/mode for 10k cycles with random stall/flush, against a reference model:
//     exact match on every valid_o = 1 cycle.

Source files
------------

// File: rtl/bcu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bcu_pkg                                                              |
// | Shared types and condition-mode codes for the branch-condition unit. |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package bcu_pkg;

   localparam int BCU_MODE_W = 3;

   typedef logic [BCU_MODE_W-1:0] bcu_mode_t;

   localparam bcu_mode_t BCU_EQ  = 3'd0;
   localparam bcu_mode_t BCU_NE  = 3'd1;
   localparam bcu_mode_t BCU_LTZ = 3'd2;
   localparam bcu_mode_t BCU_GEZ = 3'd3;
   localparam bcu_mode_t BCU_LEZ = 3'd4;
   localparam bcu_mode_t BCU_GTZ = 3'd5;
   localparam bcu_mode_t BCU_LTU = 3'd6;
   localparam bcu_mode_t BCU_NEV = 3'd7;

   typedef struct packed {
      logic zero;
      logic taken;
   } bcu_result_t;

endpackage : bcu_pkg
`default_nettype wire

// File: rtl/branch_cond_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | branch_cond_unit_if                                                  |
// | Operand/control bundle and result bundle of the branch-condition     |
// | unit; master drives operands, slave returns flags and counter.       |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
interface branch_cond_unit_if #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
);
   import bcu_pkg::*;

   logic             valid_i;
   logic             stall_i;
   logic             flush_i;
   bcu_mode_t        mode_i;
   logic [WIDTH-1:0] src_a_i;
   logic [WIDTH-1:0] src_b_i;
   logic             cnt_clr_i;

   logic             valid_o;
   logic             zero_o;
   logic             taken_o;
   logic [CNT_W-1:0] taken_cnt_o;

   modport master (
      output valid_i, stall_i, flush_i, mode_i, src_a_i, src_b_i, cnt_clr_i,
      input  valid_o, zero_o, taken_o, taken_cnt_o
   );

   modport slave (
      input  valid_i, stall_i, flush_i, mode_i, src_a_i, src_b_i, cnt_clr_i,
      output valid_o, zero_o, taken_o, taken_cnt_o
   );

endinterface : branch_cond_unit_if
`default_nettype wire

// File: rtl/bcu_eval.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bcu_eval                                                             |
// | Combinational branch-condition evaluator: (A, B, mode) -> zero/taken |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module bcu_eval
   import bcu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  wire logic [WIDTH-1:0] i_src_a,
   input  wire logic [WIDTH-1:0] i_src_b,
   input  wire bcu_mode_t        i_mode,
   output logic                  o_zero,
   output logic                  o_taken
);

   logic [WIDTH:0] w_diff;
   logic           w_eq;
   logic           w_ltu;
   logic           w_neg;
   logic           w_a_zero;

   // One extra bit keeps the difference from wrapping; its MSB is the unsigned borrow.
   assign w_diff   = {1'b0, i_src_a} - {1'b0, i_src_b};
   assign w_eq     = ~|w_diff;
   assign w_ltu    = w_diff[WIDTH];
   assign w_neg    = i_src_a[WIDTH-1];
   assign w_a_zero = ~|i_src_a;

   always_comb begin
      o_taken = 1'b0;
      case (i_mode)
         BCU_EQ:  o_taken = w_eq;
         BCU_NE:  o_taken = ~w_eq;
         BCU_LTZ: o_taken = w_neg;
         BCU_GEZ: o_taken = ~w_neg;
         BCU_LEZ: o_taken = w_neg | w_a_zero;
         BCU_GTZ: o_taken = ~w_neg & ~w_a_zero;
         BCU_LTU: o_taken = w_ltu;
         BCU_NEV: o_taken = 1'b0;
         default: o_taken = 1'b0;
      endcase
   end

   assign o_zero = w_eq;

endmodule : bcu_eval
`default_nettype wire

// File: rtl/branch_cond_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | branch_cond_unit                                                     |
// | Registered branch-condition evaluator with stall/flush and a         |
// | saturating taken-branch counter; LATENCY selects 1 or 2 stages.      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module branch_cond_unit
   import bcu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int LATENCY = 1,
   parameter int CNT_W   = 16
) (
   input  wire logic         clk_i,
   input  wire logic         rst_i,
   branch_cond_unit_if.slave bus
);

   localparam logic [CNT_W-1:0] c_cnt_max = '1;

   generate
      if (LATENCY != 1 && LATENCY != 2) begin : g_bad_latency
         $error("branch_cond_unit: LATENCY must be 1 or 2");
      end
      if (WIDTH < 2) begin : g_bad_width
         $error("branch_cond_unit: WIDTH must be >= 2");
      end
      if (CNT_W < 1) begin : g_bad_cnt_w
         $error("branch_cond_unit: CNT_W must be >= 1");
      end
   endgenerate

   logic             w_ev_valid;
   bcu_mode_t        w_ev_mode;
   logic [WIDTH-1:0] w_ev_a;
   logic [WIDTH-1:0] w_ev_b;
   logic             w_zero;
   logic             w_taken;
   logic             w_advance;
   logic             w_inc;

   logic             r_valid;
   logic             r_zero;
   logic             r_taken;
   logic [CNT_W-1:0] r_cnt;

   assign w_advance = ~bus.flush_i & ~bus.stall_i;

   // The single evaluator sits after the stage-1 register when LATENCY is 2.
   generate
      if (LATENCY == 2) begin : g_lat2
         logic             r_s1_valid;
         bcu_mode_t        r_s1_mode;
         logic [WIDTH-1:0] r_s1_a;
         logic [WIDTH-1:0] r_s1_b;

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               r_s1_valid <= 1'b0;
               r_s1_mode  <= BCU_EQ;
               r_s1_a     <= '0;
               r_s1_b     <= '0;
            end else if (bus.flush_i) begin
               r_s1_valid <= 1'b0;
            end else if (!bus.stall_i) begin
               r_s1_valid <= bus.valid_i;
               r_s1_mode  <= bus.mode_i;
               r_s1_a     <= bus.src_a_i;
               r_s1_b     <= bus.src_b_i;
            end
         end

         assign w_ev_valid = r_s1_valid;
         assign w_ev_mode  = r_s1_mode;
         assign w_ev_a     = r_s1_a;
         assign w_ev_b     = r_s1_b;
      end else begin : g_lat1
         assign w_ev_valid = bus.valid_i;
         assign w_ev_mode  = bus.mode_i;
         assign w_ev_a     = bus.src_a_i;
         assign w_ev_b     = bus.src_b_i;
      end
   endgenerate

   bcu_eval #(
      .WIDTH (WIDTH)
   ) u_eval (
      .i_src_a (w_ev_a),
      .i_src_b (w_ev_b),
      .i_mode  (w_ev_mode),
      .o_zero  (w_zero),
      .o_taken (w_taken)
   );

   // Flags load as 0 with an invalid stage so the outputs are self-gating.
   always_ff @(posedge clk_i) begin
      if (rst_i || bus.flush_i) begin
         r_valid <= 1'b0;
         r_zero  <= 1'b0;
         r_taken <= 1'b0;
      end else if (!bus.stall_i) begin
         r_valid <= w_ev_valid;
         r_zero  <= w_ev_valid & w_zero;
         r_taken <= w_ev_valid & w_taken;
      end
   end

   assign w_inc = w_advance & w_ev_valid & w_taken;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_cnt <= '0;
      end else if (!bus.stall_i) begin
         if (bus.cnt_clr_i) begin
            r_cnt <= '0;
         end else if (w_inc && (r_cnt != c_cnt_max)) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign bus.valid_o     = r_valid;
   assign bus.zero_o      = r_zero & r_valid;
   assign bus.taken_o     = r_taken & r_valid;
   assign bus.taken_cnt_o = r_cnt;

endmodule : branch_cond_unit
`default_nettype wire

// File: tb/tb_branch_cond_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_branch_cond_unit                                                  |
// | Three DUT variants (LAT1, LAT2, LAT1 with 2-bit counter) on shared   |
// | stimulus, checked against a behavioural model plus directed cases.   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_branch_cond_unit;
   import bcu_pkg::*;

   typedef struct packed {
      logic        valid;
      bcu_mode_t   mode;
      logic [31:0] a;
      logic [31:0] b;
   } entry_t;

   typedef struct packed {
      logic valid;
      logic zero;
      logic taken;
   } res_t;

   typedef struct {
      logic        valid;
      bcu_mode_t   mode;
      logic [31:0] a;
      logic [31:0] b;
      logic        e_valid;
      logic        e_zero;
      logic        e_taken;
   } vec_t;

   logic        clk;
   logic        s_rst;
   logic        s_valid;
   logic        s_stall;
   logic        s_flush;
   logic        s_clr;
   bcu_mode_t   s_mode;
   logic [31:0] s_a;
   logic [31:0] s_b;

   int n_vec;
   int n_err;

   entry_t m_s1    [3];
   res_t   m_out   [3];
   int     m_cnt   [3];
   int     lat_tab [3];
   int     cmax_tab[3];

   logic [2:0]  ov;
   logic [2:0]  oz;
   logic [2:0]  ot;
   logic [15:0] oc [3];

   branch_cond_unit_if #(.WIDTH(32), .CNT_W(16)) bus1 ();
   branch_cond_unit_if #(.WIDTH(32), .CNT_W(16)) bus2 ();
   branch_cond_unit_if #(.WIDTH(32), .CNT_W(2))  bus3 ();

   branch_cond_unit #(.WIDTH(32), .LATENCY(1), .CNT_W(16)) dut1 (.clk_i(clk), .rst_i(s_rst), .bus(bus1));
   branch_cond_unit #(.WIDTH(32), .LATENCY(2), .CNT_W(16)) dut2 (.clk_i(clk), .rst_i(s_rst), .bus(bus2));
   branch_cond_unit #(.WIDTH(32), .LATENCY(1), .CNT_W(2))  dut3 (.clk_i(clk), .rst_i(s_rst), .bus(bus3));

   assign bus1.valid_i = s_valid;  assign bus2.valid_i = s_valid;  assign bus3.valid_i = s_valid;
   assign bus1.stall_i = s_stall;  assign bus2.stall_i = s_stall;  assign bus3.stall_i = s_stall;
   assign bus1.flush_i = s_flush;  assign bus2.flush_i = s_flush;  assign bus3.flush_i = s_flush;
   assign bus1.mode_i  = s_mode;   assign bus2.mode_i  = s_mode;   assign bus3.mode_i  = s_mode;
   assign bus1.src_a_i = s_a;      assign bus2.src_a_i = s_a;      assign bus3.src_a_i = s_a;
   assign bus1.src_b_i = s_b;      assign bus2.src_b_i = s_b;      assign bus3.src_b_i = s_b;
   assign bus1.cnt_clr_i = s_clr;  assign bus2.cnt_clr_i = s_clr;  assign bus3.cnt_clr_i = s_clr;

   assign ov = {bus3.valid_o, bus2.valid_o, bus1.valid_o};
   assign oz = {bus3.zero_o,  bus2.zero_o,  bus1.zero_o};
   assign ot = {bus3.taken_o, bus2.taken_o, bus1.taken_o};
   assign oc[0] = bus1.taken_cnt_o;
   assign oc[1] = bus2.taken_cnt_o;
   assign oc[2] = {14'd0, bus3.taken_cnt_o};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Condition rules written directly from the mode definitions.
   function automatic res_t ref_eval(input entry_t e);
      res_t r;
      r = '0;
      if (e.valid) begin
         r.valid = 1'b1;
         r.zero  = (e.a == e.b);
         case (e.mode)
            BCU_EQ:  r.taken = (e.a == e.b);
            BCU_NE:  r.taken = (e.a != e.b);
            BCU_LTZ: r.taken = ($signed(e.a) <  0);
            BCU_GEZ: r.taken = ($signed(e.a) >= 0);
            BCU_LEZ: r.taken = ($signed(e.a) <= 0);
            BCU_GTZ: r.taken = ($signed(e.a) >  0);
            BCU_LTU: r.taken = (e.a < e.b);
            default: r.taken = 1'b0;
         endcase
      end
      return r;
   endfunction

   task automatic model_step();
      entry_t in_e;
      in_e.valid = s_valid;
      in_e.mode  = s_mode;
      in_e.a     = s_a;
      in_e.b     = s_b;
      for (int d = 0; d < 3; d++) begin
         if (s_rst) begin
            m_s1[d] = '0; m_out[d] = '0; m_cnt[d] = 0;
         end else if (s_flush) begin
            m_s1[d] = '0; m_out[d] = '0;
         end else if (!s_stall) begin
            if (lat_tab[d] == 1) begin
               m_out[d] = ref_eval(in_e);
            end else begin
               m_out[d] = ref_eval(m_s1[d]);
               m_s1[d]  = in_e;
            end
            if (s_clr) m_cnt[d] = 0;
            else if (m_out[d].taken && m_cnt[d] < cmax_tab[d]) m_cnt[d] = m_cnt[d] + 1;
         end
      end
   endtask

   task automatic check_vec(input string name, input int d, input logic ev, input logic ez,
                            input logic et, input int ec);
      n_vec = n_vec + 1;
      if (ov[d] !== ev || oz[d] !== ez || ot[d] !== et || int'(oc[d]) != ec) begin
         n_err = n_err + 1;
         $display("FAIL %s dut%0d: got valid=%b zero=%b taken=%b cnt=%0d, want valid=%b zero=%b taken=%b cnt=%0d",
                  name, d, ov[d], oz[d], ot[d], oc[d], ev, ez, et, ec);
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 3; d++)
         check_vec("model", d, m_out[d].valid, m_out[d].zero, m_out[d].taken, m_cnt[d]);
   endtask

   task automatic drive(input logic v, input bcu_mode_t m, input logic [31:0] a, input logic [31:0] b);
      s_valid = v; s_mode = m; s_a = a; s_b = b;
   endtask

   vec_t tbl [15];

   initial begin
      tbl[0]  = '{1'b1, BCU_EQ,  32'h7,        32'h7,        1'b1, 1'b1, 1'b1};
      tbl[1]  = '{1'b1, BCU_EQ,  32'h7,        32'h8,        1'b1, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, BCU_NE,  32'h7,        32'h8,        1'b1, 1'b0, 1'b1};
      tbl[3]  = '{1'b1, BCU_LTZ, 32'hFFFFFFFF, 32'h0,        1'b1, 1'b0, 1'b1};
      tbl[4]  = '{1'b1, BCU_GEZ, 32'h0,        32'h0,        1'b1, 1'b1, 1'b1};
      tbl[5]  = '{1'b1, BCU_GEZ, 32'h80000000, 32'h1,        1'b1, 1'b0, 1'b0};
      tbl[6]  = '{1'b1, BCU_LEZ, 32'h0,        32'h5,        1'b1, 1'b0, 1'b1};
      tbl[7]  = '{1'b1, BCU_LEZ, 32'h1,        32'h1,        1'b1, 1'b1, 1'b0};
      tbl[8]  = '{1'b1, BCU_GTZ, 32'h7FFFFFFF, 32'h0,        1'b1, 1'b0, 1'b1};
      tbl[9]  = '{1'b1, BCU_GTZ, 32'h80000000, 32'h0,        1'b1, 1'b0, 1'b0};
      tbl[10] = '{1'b1, BCU_LTU, 32'h0,        32'hFFFFFFFF, 1'b1, 1'b0, 1'b1};
      tbl[11] = '{1'b1, BCU_LTU, 32'hFFFFFFFF, 32'h0,        1'b1, 1'b0, 1'b0};
      tbl[12] = '{1'b1, BCU_LTU, 32'h5,        32'h5,        1'b1, 1'b1, 1'b0};
      tbl[13] = '{1'b1, BCU_NEV, 32'h3,        32'h3,        1'b1, 1'b1, 1'b0};
      tbl[14] = '{1'b0, BCU_EQ,  32'h3,        32'h3,        1'b0, 1'b0, 1'b0};

      lat_tab  = '{1, 2, 1};
      cmax_tab = '{65535, 65535, 3};
      n_vec = 0;
      n_err = 0;
      for (int d = 0; d < 3; d++) begin
         m_s1[d] = '0; m_out[d] = '0; m_cnt[d] = 0;
      end
      s_rst = 1'b1; s_stall = 1'b0; s_flush = 1'b0; s_clr = 1'b0;
      drive(1'b0, BCU_EQ, 32'h0, 32'h0);

      // Reset then idle: everything quiet.
      for (int i = 0; i < 3; i++) begin
         tick();
         for (int d = 0; d < 3; d++) check_vec("reset", d, 1'b0, 1'b0, 1'b0, 0);
      end
      s_rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         for (int d = 0; d < 3; d++) check_vec("idle", d, 1'b0, 1'b0, 1'b0, 0);
      end

      // EQ then NE on equal operands, single-cycle variant.
      drive(1'b1, BCU_EQ, 32'h1234, 32'h1234);
      tick(); check_vec("lat1_eq", 0, 1'b1, 1'b1, 1'b1, 1);
      drive(1'b1, BCU_NE, 32'h1234, 32'h1234);
      tick(); check_vec("lat1_ne", 0, 1'b1, 1'b1, 1'b0, 1);
      drive(1'b0, BCU_EQ, 32'h0, 32'h0);
      tick();

      // Three back-to-back accepts on the two-stage variant.
      drive(1'b1, BCU_LTZ, 32'h80000000, 32'h0);
      tick();
      drive(1'b1, BCU_GTZ, 32'h0, 32'h0);
      tick(); check_vec("lat2_ltz", 1, 1'b1, 1'b0, 1'b1, 2);
      drive(1'b1, BCU_LTU, 32'h1, 32'hFFFFFFFF);
      tick(); check_vec("lat2_gtz", 1, 1'b1, 1'b1, 1'b0, 2);
      drive(1'b0, BCU_EQ, 32'h0, 32'h0);
      tick(); check_vec("lat2_ltu", 1, 1'b1, 1'b0, 1'b1, 3);

      // Stall holds everything, flush during stall kills the in-flight result.
      drive(1'b1, BCU_EQ, 32'h5, 32'h5);
      tick();
      tick(); check_vec("pre_stall", 1, 1'b1, 1'b1, 1'b1, 4);
      drive(1'b1, BCU_NE, 32'h1, 32'h2);
      s_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(); check_vec("stall_hold", 1, 1'b1, 1'b1, 1'b1, 4);
      end
      s_flush = 1'b1;
      tick(); check_vec("flush", 1, 1'b0, 1'b0, 1'b0, 4);
      s_flush = 1'b0; s_stall = 1'b0;
      drive(1'b0, BCU_EQ, 32'h0, 32'h0);
      tick(); check_vec("post_flush", 1, 1'b0, 1'b0, 1'b0, 4);

      // Two-bit counter saturation, then clear beating a taken load.
      s_rst = 1'b1;
      tick();
      s_rst = 1'b0;
      drive(1'b1, BCU_EQ, 32'h9, 32'h9);
      for (int i = 1; i <= 5; i++) begin
         tick(); check_vec("sat", 2, 1'b1, 1'b1, 1'b1, (i < 3) ? i : 3);
      end
      s_clr = 1'b1;
      tick(); check_vec("clr_vs_inc", 2, 1'b1, 1'b1, 1'b1, 0);
      s_clr = 1'b0;
      drive(1'b0, BCU_EQ, 32'h0, 32'h0);
      tick(); check_vec("after_clr", 2, 1'b0, 1'b0, 1'b0, 0);

      // Directed mode table on the single-cycle variant.
      s_rst = 1'b1;
      tick();
      s_rst = 1'b0;
      for (int i = 0; i < 15; i++) begin
         drive(tbl[i].valid, tbl[i].mode, tbl[i].a, tbl[i].b);
         tick();
         check_vec($sformatf("tbl%0d", i), 0, tbl[i].e_valid, tbl[i].e_zero, tbl[i].e_taken, m_cnt[0]);
      end

      // Random traffic with stall/flush; the model check inside tick covers every cycle.
      for (int i = 0; i < 10000; i++) begin
         int sel;
         sel     = int'($urandom_range(0, 3));
         s_valid = ($urandom_range(0, 3) != 0);
         s_mode  = bcu_mode_t'($urandom_range(0, 7));
         s_a     = $urandom;
         s_b     = $urandom;
         if (sel == 0) s_b = s_a;
         else if (sel == 1) s_a = 32'($urandom_range(0, 2)) - 32'd1;
         else if (sel == 2) s_a = {s_a[31], 31'd0};
         s_stall = ($urandom_range(0, 9) == 0);
         s_flush = ($urandom_range(0, 19) == 0);
         s_clr   = !s_stall && !s_flush && ($urandom_range(0, 49) == 0);
         tick();
      end
      s_stall = 1'b0; s_flush = 1'b0; s_clr = 1'b0;
      drive(1'b0, BCU_EQ, 32'h0, 32'h0);
      for (int i = 0; i < 3; i++) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_branch_cond_unit
`default_nettype wire
